// File: rtl/register_file_sb.sv
// Register file with 2 combinational read ports, 1 synchronous write port,
// same-cycle write-to-read bypass, optional hardwired zero register, and a
// per-register pending-write scoreboard with a registered pending count.
// Reads and reserves come from decode/issue; writes come from writeback.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_reg,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic wr_ok;       // write actually lands in the array
  logic res_ok;      // reserve actually targets a trackable register
  logic res_new;     // reserve turns a clear bit into a pending bit
  logic wr_release;  // write clears a pending bit that is not re-reserved
  logic hit1, hit2;  // bypass hits on the read ports

  assign wr_ok  = write_enable && !((ZERO_REG != 0) && (write_reg == '0));
  assign res_ok = reserve_enable && !((ZERO_REG != 0) && (reserve_reg == '0));

  // The count tracks popcount(pending) incrementally: a re-reserve of the
  // register being written keeps its bit set, so it is neither +1 nor -1.
  assign res_new    = res_ok && !pending_q[reserve_reg];
  assign wr_release = write_enable && pending_q[write_reg]
                      && !(res_ok && (reserve_reg == write_reg));

  assign hit1 = (BYPASS != 0) && wr_ok && (write_reg == read_reg1);
  assign hit2 = (BYPASS != 0) && wr_ok && (write_reg == read_reg2);

  // Zero register overrides bypass; forwarded data is never "busy" since
  // the value being produced is already on the port.
  assign read_data1 = ((ZERO_REG != 0) && (read_reg1 == '0)) ? '0 :
                      hit1 ? write_data : regs_q[read_reg1];
  assign read_data2 = ((ZERO_REG != 0) && (read_reg2 == '0)) ? '0 :
                      hit2 ? write_data : regs_q[read_reg2];
  assign busy1 = hit1 ? 1'b0 : pending_q[read_reg1];
  assign busy2 = hit2 ? 1'b0 : pending_q[read_reg2];

  assign pending_count = count_q;

  // Scoreboard next state: flush beats reserve, reserve beats write-release.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    pending_d = pending_q;
    count_d   = count_q;
    if (flush) begin
      pending_d = '0;
      count_d   = '0;
    end else begin
      if (write_enable) pending_d[write_reg]   = 1'b0;
      if (res_ok)       pending_d[reserve_reg] = 1'b1;
      count_d = count_q + CNT_W'(res_new) - CNT_W'(wr_release);
    end
  end

  // Register array write port; data writes are unaffected by flush.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: this array is built from flops and must read as zero straight
    // after reset, so it is cleared here; a RAM macro could not be.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      regs_q[write_reg] <= write_data;
    end
  end

  // Scoreboard and pending-count state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares on each falling
// clock edge. A second instance with BYPASS=0 shares all inputs.
module tb_register_file_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0;
  logic        write_enable = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic        reserve_enable = 1'b0;
  logic [4:0]  reserve_reg = '0;
  logic        flush = 1'b0;

  logic [31:0] read_data1, read_data2;
  logic        busy1, busy2;
  logic [5:0]  pending_count;

  logic [31:0] nb_read_data1, nb_read_data2;
  logic        nb_busy1, nb_busy2;
  logic [5:0]  nb_pending_count;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
    logic [31:0] nb_rd1;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .busy1(busy1), .busy2(busy2),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
    .flush(flush), .pending_count(pending_count)
  );

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clock(clock), .reset(reset),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(nb_read_data1), .read_data2(nb_read_data2),
    .busy1(nb_busy1), .busy2(nb_busy2),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .reserve_enable(reserve_enable), .reserve_reg(reserve_reg),
    .flush(flush), .pending_count(nb_pending_count)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: compare the pending expectation once per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".rd1"},    read_data1,            e.rd1);
        check({e.name, ".rd2"},    read_data2,            e.rd2);
        check({e.name, ".busy1"},  {31'b0, busy1},        {31'b0, e.b1});
        check({e.name, ".busy2"},  {31'b0, busy2},        {31'b0, e.b2});
        check({e.name, ".count"},  {26'b0, pending_count},    {26'b0, e.cnt});
        check({e.name, ".nb_rd1"}, nb_read_data1,         e.nb_rd1);
        check({e.name, ".nb_count"}, {26'b0, nb_pending_count}, {26'b0, e.cnt});
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge.
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic re, input logic [4:0] rr, input logic fl);
    @(posedge clock);
    #1;
    read_reg1 = r1; read_reg2 = r2;
    write_enable = we; write_reg = wr; write_data = wd;
    reserve_enable = re; reserve_reg = rr; flush = fl;
  endtask

  task automatic expect_out(input string name, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic b1, input logic b2,
                            input logic [5:0] cnt, input logic [31:0] nb_rd1);
    exp_t e;
    e.name = name; e.rd1 = rd1; e.rd2 = rd2; e.b1 = b1; e.b2 = b2;
    e.cnt = cnt; e.nb_rd1 = nb_rd1;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    //    r1  r2  we  wr  wd            re  rr  fl
    drive(1,  31, 0,  0,  32'h0,        0,  0,  0);
    expect_out("reset",      32'h0,        32'h0, 0, 0, 0, 32'h0);
    drive(1,  31, 1,  1,  32'hAABBCCDD, 0,  0,  0);
    expect_out("wr_bypass",  32'hAABBCCDD, 32'h0, 0, 0, 0, 32'h0);
    drive(1,  31, 0,  0,  32'h0,        0,  0,  0);
    expect_out("wr_after",   32'hAABBCCDD, 32'h0, 0, 0, 0, 32'hAABBCCDD);
    drive(0,  1,  1,  0,  32'hDEADBEEF, 1,  0,  0);
    expect_out("zero_reg",   32'h0, 32'hAABBCCDD, 0, 0, 0, 32'h0);
    drive(0,  1,  0,  0,  32'h0,        0,  0,  0);
    expect_out("zero_after", 32'h0, 32'hAABBCCDD, 0, 0, 0, 32'h0);
    drive(3,  4,  0,  0,  32'h0,        1,  3,  0);
    expect_out("res3",       32'h0, 32'h0, 0, 0, 0, 32'h0);
    drive(3,  4,  0,  0,  32'h0,        1,  4,  0);
    expect_out("res4",       32'h0, 32'h0, 1, 0, 1, 32'h0);
    drive(4,  3,  0,  0,  32'h0,        0,  0,  0);
    expect_out("pend2",      32'h0, 32'h0, 1, 1, 2, 32'h0);
    drive(4,  3,  1,  3,  32'hFACEBEEF, 0,  0,  0);
    expect_out("wb3_bypass", 32'h0, 32'hFACEBEEF, 1, 0, 2, 32'h0);
    drive(3,  4,  0,  0,  32'h0,        0,  0,  0);
    expect_out("wb3_after",  32'hFACEBEEF, 32'h0, 0, 1, 1, 32'hFACEBEEF);
    drive(5,  4,  0,  0,  32'h0,        1,  5,  0);
    expect_out("res5",       32'h0, 32'h0, 0, 1, 1, 32'h0);
    drive(5,  4,  1,  5,  32'h12345678, 1,  5,  0);
    expect_out("res_wr5",    32'h12345678, 32'h0, 0, 1, 2, 32'h0);
    drive(5,  6,  0,  0,  32'h0,        1,  6,  1);
    expect_out("flush_res6", 32'h12345678, 32'h0, 1, 0, 2, 32'h12345678);
    drive(5,  6,  0,  0,  32'h0,        0,  0,  0);
    expect_out("after_flush", 32'h12345678, 32'h0, 0, 0, 0, 32'h12345678);
    drive(7,  5,  1,  7,  32'h0BADF00D, 0,  0,  1);
    expect_out("flush_wr",   32'h0BADF00D, 32'h12345678, 0, 0, 0, 32'h0);
    drive(7,  5,  0,  0,  32'h0,        1,  7,  0);
    expect_out("res7",       32'h0BADF00D, 32'h12345678, 0, 0, 0, 32'h0BADF00D);
    drive(7,  5,  0,  0,  32'h0,        1,  8,  0);
    expect_out("res8",       32'h0BADF00D, 32'h12345678, 1, 0, 1, 32'h0BADF00D);
    drive(7,  5,  0,  0,  32'h0,        1,  9,  0);
    expect_out("res9",       32'h0BADF00D, 32'h12345678, 1, 0, 2, 32'h0BADF00D);
    drive(7,  5,  0,  0,  32'h0,        1,  7,  0);
    expect_out("reres7",     32'h0BADF00D, 32'h12345678, 1, 0, 3, 32'h0BADF00D);
    drive(9,  7,  0,  0,  32'h0,        0,  0,  0);
    expect_out("cnt3",       32'h0, 32'h0BADF00D, 1, 1, 3, 32'h0);

    // Reset pulled low between edges; the mid-cycle sample precedes any
    // further rising edge, so the clear must be asynchronous.
    drive(7,  5,  0,  0,  32'h0,        0,  0,  0);
    expect_out("async_rst",  32'h0, 32'h0, 0, 0, 0, 32'h0);
    #1 reset = 1'b0;
    drive(7,  9,  0,  0,  32'h0,        0,  0,  0);
    reset = 1'b1;
    expect_out("post_rst",   32'h0, 32'h0, 0, 0, 0, 32'h0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the single-issue register file: 2 asynchronous read ports, 1 synchronous write port, same-cycle write-to-read bypass, hardwired zero register. It adds a per-register pending-write scoreboard (reserve on issue, release on writeback) and a registered pending-count. It sits between the decode/issue stage (reads, reserves) and the writeback stage (writes) of the pipelined core.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never becomes pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately
read_reg1  input  ADDR_WIDTH  read port 1 index
read_reg2  input  ADDR_WIDTH  read port 2 index
read_data1  output  DATA_WIDTH  read port 1 data (combinational)
read_data2  output  DATA_WIDTH  read port 2 data (combinational)
busy1  output  1  pending-write status of read_reg1 (combinational)
busy2  output  1  pending-write status of read_reg2 (combinational)
write_enable  input  1  writeback strobe
write_reg  input  ADDR_WIDTH  writeback index
write_data  input  DATA_WIDTH  writeback data
reserve_enable  input  1  issue strobe: mark reserve_reg pending
reserve_reg  input  ADDR_WIDTH  register to reserve
flush  input  1  clear all pending bits (pipeline flush)
pending_count  output  ADDR_WIDTH+1  registered count of pending registers

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all pending bits = 0, pending_count = 0. Read outputs then follow from the cleared state: read_data* = 0, busy* = 0.
- Write: on posedge, if write_enable, regs[write_reg] <= write_data. Skipped for write_reg = 0 when ZERO_REG = 1.
- Read: read_data_n = regs[read_reg_n], with two overrides:
  - BYPASS = 1, write_enable = 1, write_reg == read_reg_n, and the register is writable: read_data_n = write_data.
  - ZERO_REG = 1 and read_reg_n = 0: read_data_n = 0, overriding bypass.
- Scoreboard: pending[i] updates on posedge. Priority, highest first:
  - flush: all bits <= 0.
  - reserve: pending[reserve_reg] <= 1.
  - write: pending[write_reg] <= 0.
- Same-index reserve and write in one cycle: reserve wins (new producer); the bit ends at 1 and the data write still occurs.
- flush with a write in the same cycle: the write still updates data. flush with a reserve in the same cycle: the reserve is dropped.
- ZERO_REG = 1: reserve of register 0 is ignored; pending[0] is always 0.
- busy_n = pending[read_reg_n], except busy_n = 0 when BYPASS = 1 and the bypass hit above applies. Forwarded data is valid even if the same edge re-reserves the register.
- Write to a non-pending register: data updates, pending unchanged (legal).
- Reserve of an already-pending register: the bit stays 1 and the count is unchanged.
- pending_count is registered and always equals the popcount of the pending bits after the edge. Update rule:
  - +1 if the reserve targets a non-pending register.
  - −1 if the write clears a pending register whose index differs from the reserved one.
  - Set to 0 on flush.
  - Never wraps: maximum 2**ADDR_WIDTH − ZERO_REG.
- Reset asserted mid-operation: immediate clear regardless of clock. A write/reserve presented on the edge coinciding with reset deassertion is not required to take effect.
- Latency: read is 0 cycles (combinational). Write, reserve, flush and count are visible 1 edge later.

Test Plan:
- Reset/clear: hold reset=0 for 2 cycles, release, read regs 1 and 31 -> read_data1 = read_data2 = 0, busy* = 0, pending_count = 0.
- Write + bypass: write_enable=1, write_reg=1, write_data=AABBCCDD, read_reg1=1 in the same cycle -> read_data1 = AABBCCDD before the edge and after it with write_enable=0. Repeat with BYPASS=0 -> 00000000 before the edge, AABBCCDD after.
- Zero register: write DEADBEEF to reg 0 and reserve reg 0 -> read_data1 = 0, busy1 = 0, pending_count unchanged.
- Scoreboard: reserve 3, then 4 on consecutive edges -> pending_count = 2, busy2 = 1 for read_reg2 = 3. Write FACEBEEF to 3 -> busy2 = 0 during the write cycle, read_data2 = FACEBEEF, count = 1.
- Simultaneous events: in one cycle reserve 5 and write 12345678 to 5 (5 pending) -> reg5 = 12345678, busy for 5 = 1, count unchanged. Next cycle flush + reserve 6 -> count = 0, busy for 6 = 0.
- Async reset mid-run: with count = 3 and regs loaded, pull reset low between edges -> all outputs 0 within the same timestep, no clock edge needed.
